// File: rtl/smem_core_port.sv
// ---------------------------------------------------------------------------
// smem_core_port
//
// Core-side initiator for port B of a shared-memory dual-port RAM bank.
// A core issues reads and writes over a valid/ready request channel; this
// block drives the RAM's port B directly and collects read data, one cycle
// after the address edge, into a small response FIFO. Responses go back to
// the core in acceptance order, carrying the tag of the originating read.
//
// Request credits: a read is only accepted when a FIFO slot is guaranteed
// for it. The FIFO can therefore never overflow. Writes pass the same ready
// check but produce no response and take no credit.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    core request valid
//   req_ready    request accepted on an edge where valid & ready
//   req_we       1 = write, 0 = read
//   req_addr     word address within the local bank
//   req_wdata    write data
//   req_tag      read tag, echoed on the response
//   rsp_valid    read response valid
//   rsp_ready    core accepts the response
//   rsp_rdata    read data
//   rsp_tag      tag of the originating read
//   ram_we_b     RAM port B write enable
//   ram_addr_b   RAM port B address
//   ram_wdata_b  RAM port B write data
//   ram_rdata_b  RAM port B read data, valid one cycle after the address edge
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module smem_core_port #(
    parameter int LOCAL_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH       = 32,
    parameter int TAG_WIDTH        = 4,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [LOCAL_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]       req_wdata,
    input  logic [TAG_WIDTH-1:0]        req_tag,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic [TAG_WIDTH-1:0]        rsp_tag,
    output logic                        ram_we_b,
    output logic [LOCAL_ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0]       ram_wdata_b,
    input  logic [DATA_WIDTH-1:0]       ram_rdata_b
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = DATA_WIDTH + TAG_WIDTH;

    logic                 infl_v;
    logic [TAG_WIDTH-1:0] infl_tag;

    logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        rd_ptr_next;
    logic [CW-1:0]        fifo_cnt;
    logic [CW-1:0]        fifo_cnt_next;
    logic [CW-1:0]        fifo_survivors;
    logic [CW-1:0]        count;

    logic                 req_accept;
    logic                 rd_accept;
    logic                 push;
    logic                 pop;
    logic [EW-1:0]        push_entry;
    logic [EW-1:0]        head_next;

    // Outstanding reads: those already queued plus the one whose data is
    // still coming out of the RAM. Built from registers only, so req_ready
    // has no combinational path from rsp_ready or req_valid.
    assign count      = fifo_cnt + CW'(infl_v);
    assign req_ready  = ~rst & (count < CW'(FIFO_DEPTH));
    assign req_accept = req_valid & req_ready;
    assign rd_accept  = req_accept & ~req_we;

    // Port B is driven straight from the request; the RAM registers it.
    assign ram_we_b    = req_accept & req_we & ~rst;
    assign ram_addr_b  = req_addr;
    assign ram_wdata_b = req_wdata;

    // The in-flight read lands in the FIFO on the edge after it was issued.
    assign push       = infl_v;
    assign pop        = rsp_valid & rsp_ready;
    assign push_entry = {ram_rdata_b, infl_tag};

    // Work out the FIFO state after this edge and which entry will be the
    // new head. If the FIFO is empty once any pop is applied, the entry
    // being pushed is the head and must bypass the storage array.
    always_comb begin
        rd_ptr_next    = rd_ptr;
        fifo_cnt_next  = fifo_cnt;
        fifo_survivors = fifo_cnt - CW'(pop);
        if (pop) begin
            rd_ptr_next = rd_ptr + PW'(1);
        end
        fifo_cnt_next = fifo_survivors + CW'(push);
        head_next     = fifo_mem[rd_ptr_next];
        if (push && (fifo_survivors == '0)) begin
            head_next = push_entry;
        end
    end

    // Control state and the registered response head. The response
    // registers are only reloaded when the FIFO stays non-empty, so they
    // hold steady while the core stalls and keep their last value once
    // drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_v    <= 1'b0;
            infl_tag  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_tag   <= '0;
        end else begin
            infl_v <= rd_accept;
            if (rd_accept) begin
                infl_tag <= req_tag;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr    <= rd_ptr_next;
            fifo_cnt  <= fifo_cnt_next;
            rsp_valid <= (fifo_cnt_next != '0);
            if (fifo_cnt_next != '0) begin
                {rsp_rdata, rsp_tag} <= head_next;
            end
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: tb/tb_smem_core_port.sv
// ---------------------------------------------------------------------------
// tb_smem_core_port
//
// Drives smem_core_port against a behavioural port-B RAM and compares every
// cycle with a transaction-level reference: a word array updated at write
// acceptance and a queue of expected responses, each becoming visible two
// edges after its read was accepted. Outstanding reads are the queue length,
// which also gives the expected req_ready.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_smem_core_port;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [TW-1:0] req_tag;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [TW-1:0] rsp_tag;
    logic          ram_we_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_wdata_b;
    logic [DW-1:0] ram_rdata_b;

    smem_core_port #(
        .LOCAL_ADDR_WIDTH(AW),
        .DATA_WIDTH      (DW),
        .TAG_WIDTH       (TW),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_tag    (rsp_tag),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_wdata_b(ram_wdata_b),
        .ram_rdata_b(ram_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port B of the RAM bank: synchronous write, registered read.
    logic [DW-1:0] ram [1 << AW];
    always @(posedge clk) begin
        if (ram_we_b) begin
            ram[ram_addr_b] <= ram_wdata_b;
        end
        ram_rdata_b <= ram[ram_addr_b];
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            vis;
    } exp_t;

    logic [DW-1:0] ref_mem [1 << AW];
    exp_t          exp_q [$];
    int            edge_cnt;
    int            checks;
    int            errors;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare just after, then
    // advance the reference model across the rising edge.
    task automatic run_cycle(input logic v, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [TW-1:0] t, input logic rr);
        logic exp_ready;
        logic exp_valid;
        logic acc;
        logic pp;
        exp_t e;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_tag   = t;
        rsp_ready = rr;
        #1;
        exp_ready = (exp_q.size() < DEPTH);
        exp_valid = (exp_q.size() != 0) && (exp_q[0].vis <= edge_cnt);
        check("req_ready", req_ready, exp_ready);
        check("ram_we_b", ram_we_b, v & exp_ready & we);
        check("ram_addr_b", ram_addr_b, a);
        if (v && we) check("ram_wdata_b", ram_wdata_b, d);
        check("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid) begin
            check("rsp_rdata", rsp_rdata, exp_q[0].data);
            check("rsp_tag", rsp_tag, exp_q[0].tag);
        end
        acc = v & exp_ready;
        pp  = exp_valid & rr;
        @(posedge clk);
        edge_cnt++;
        if (pp) void'(exp_q.pop_front());
        if (acc) begin
            if (we) begin
                ref_mem[a] = d;
            end else begin
                e.data = ref_mem[a];
                e.tag  = t;
                e.vis  = edge_cnt + 1;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset between edges with a write request pending; the
    // outputs must collapse at once and every queued response is lost.
    task automatic pulse_reset();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_ram_we_b", ram_we_b, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        edge_cnt  = 0;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end

        // Reset state with a write request held on the inputs.
        @(negedge clk);
        check("reset_req_ready", req_ready, 1'b0);
        check("reset_ram_we_b", ram_we_b, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_tag", rsp_tag, 4'h0);
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        check("release_req_ready", req_ready, 1'b1);
        @(negedge clk);

        // Top address write, then read it back with tag 5.
        run_cycle(1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF, 4'h0, 1'b1);
        run_cycle(1'b1, 1'b0, 10'h3FF, 32'h0, 4'h5, 1'b1);
        repeat (3) run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1);

        // Eight back-to-back reads with the core always ready.
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, 1'b0, AW'(i), 32'h0, TW'(i), 1'b1);
        end
        repeat (3) run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1);

        // Core stalls: credits run out after a full FIFO, then drain.
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, 1'b0, AW'($urandom_range(0, 1023)), 32'h0, TW'(8 + i), 1'b0);
        end
        repeat (6) run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1);

        // Write followed on the very next edge by a read of the same word.
        run_cycle(1'b1, 1'b1, 10'h010, 32'hA5A5A5A5, 4'h0, 1'b1);
        run_cycle(1'b1, 1'b0, 10'h010, 32'h0, 4'h3, 1'b1);
        repeat (3) run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1);

        // Two reads pending when reset hits; nothing may surface afterwards.
        run_cycle(1'b1, 1'b0, 10'h020, 32'h0, 4'h1, 1'b0);
        run_cycle(1'b1, 1'b0, 10'h021, 32'h0, 4'h2, 1'b0);
        pulse_reset();
        repeat (4) run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1);

        // Randomised traffic over a small address window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      AW'($urandom_range(0, 15)), $urandom, TW'($urandom_range(0, 15)),
                      $urandom_range(0, 3) != 0);
        end
        repeat (8) run_cycle(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
